hit_popup_renderer: RTL and testbench

- Downstream consumer of the perfect-hit sprite RAM: turns the VGA beam position into a sprite read address and tracks the popup's on-screen lifetime.
- Converts the returned 3-bit palette index into a 24-bit RGB overlay pixel with a valid flag.
- Feeds the top-level colour mux, which selects `ovl_rgb` whenever `ovl_valid` is high.
- A perfect-hit pulse from the judgement logic triggers the popup. The popup shows, blinks, then disappears, drifting upward as it ages.

---
 rtl/hit_popup_renderer.sv | 220 ++++++++++++++++++++++
 tb/tb_hit_popup_renderer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_popup_renderer.sv
// ============================================================================
//  Module   : hit_popup_renderer
//  Purpose  : Draws the "perfect hit" popup sprite over the VGA picture.
//             - Turns the beam position into a sprite RAM read address.
//             - Tracks the popup lifetime: shown, then blinking, then gone.
//             - Drifts the popup upward as it ages.
//             - Maps the returned palette index to a 24-bit RGB overlay pixel.
//  Ports    : Clk, Reset_n           - clock, asynchronous active-low reset
//             DrawX, DrawY           - current beam position
//             frame_start            - one pulse per frame (vertical blank)
//             hit_perfect            - one pulse: trigger / retrigger popup
//             read_address           - registered sprite RAM address
//             spr_data               - palette index, one cycle after address
//             ovl_rgb, ovl_valid     - overlay pixel (3 cycles after DrawX/Y)
//             popup_active           - popup is on screen (SHOW or BLINK)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hit_popup_renderer #(
  parameter int SPR_W        = 157,
  parameter int SPR_H        = 136,
  parameter int POS_X        = 241,
  parameter int POS_Y        = 180,
  parameter int SHOW_FRAMES  = 60,
  parameter int BLINK_FRAMES = 20,
  parameter int BLINK_PERIOD = 4,
  parameter int RISE_DIV     = 3,
  parameter int RISE_MAX     = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic        hit_perfect,
  output logic [18:0] read_address,
  input  logic [2:0]  spr_data,
  output logic [23:0] ovl_rgb,
  output logic        ovl_valid,
  output logic        popup_active
);

  localparam int CNT_W  = $clog2(SHOW_FRAMES + 1);
  localparam int RISE_W = $clog2(RISE_MAX + 1);
  localparam int RDIV_W = $clog2(RISE_DIV + 1);
  localparam int BDIV_W = $clog2(BLINK_PERIOD + 1);

  localparam logic [CNT_W-1:0]  C_SHOW_CNT  = CNT_W'(SHOW_FRAMES);
  localparam logic [CNT_W-1:0]  C_BLINK_CNT = CNT_W'(BLINK_FRAMES);
  localparam logic [RISE_W-1:0] C_RISE_MAX  = RISE_W'(RISE_MAX);
  localparam logic [RDIV_W-1:0] C_RDIV_LAST = RDIV_W'(RISE_DIV - 1);
  localparam logic [BDIV_W-1:0] C_BDIV_LAST = BDIV_W'(BLINK_PERIOD - 1);
  localparam logic [10:0]       C_POS_X     = 11'(POS_X);
  localparam logic [10:0]       C_POS_Y     = 11'(POS_Y);
  localparam logic [10:0]       C_SPR_W11   = 11'(SPR_W);
  localparam logic [10:0]       C_SPR_H11   = 11'(SPR_H);
  localparam logic [18:0]       C_SPR_W19   = 19'(SPR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLINK = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [RISE_W-1:0]   rise_q, rise_d;
  logic [RDIV_W-1:0]   rise_div_q, rise_div_d;
  logic [BDIV_W-1:0]   blink_div_q, blink_div_d;
  logic                visible_q, visible_d;
  logic                popup_active_q, popup_active_d;

  // --------------------------------------------------------------------------
  // Lifetime FSM next-state logic. A hit always wins over frame_start, so a
  // retrigger in the same cycle as a frame tick restarts from a clean state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    rise_d      = rise_q;
    rise_div_d  = rise_div_q;
    blink_div_d = blink_div_q;
    visible_d   = visible_q;

    if (hit_perfect) begin
      state_d     = S_SHOW;
      frame_cnt_d = C_SHOW_CNT;
      rise_d      = '0;
      rise_div_d  = '0;
      blink_div_d = '0;
      visible_d   = 1'b1;
    end else if (frame_start && (state_q != S_IDLE)) begin
      frame_cnt_d = frame_cnt_q - CNT_W'(1);

      // Upward drift: one pixel every RISE_DIV frames, capped.
      if (rise_div_q == C_RDIV_LAST) begin
        rise_div_d = '0;
        if (rise_q != C_RISE_MAX) begin
          rise_d = rise_q + RISE_W'(1);
        end
      end else begin
        rise_div_d = rise_div_q + RDIV_W'(1);
      end

      if (state_q == S_SHOW) begin
        if (frame_cnt_d == C_BLINK_CNT) begin
          state_d     = S_BLINK;
          blink_div_d = '0;
          visible_d   = 1'b1;
        end
      end else begin
        if (blink_div_q == C_BDIV_LAST) begin
          blink_div_d = '0;
          visible_d   = ~visible_q;
        end else begin
          blink_div_d = blink_div_q + BDIV_W'(1);
        end
        if (frame_cnt_d == '0) begin
          state_d = S_IDLE;
        end
      end
    end

    popup_active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= S_IDLE;
      frame_cnt_q    <= '0;
      rise_q         <= '0;
      rise_div_q     <= '0;
      blink_div_q    <= '0;
      visible_q      <= 1'b0;
      popup_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      rise_q         <= rise_d;
      rise_div_q     <= rise_div_d;
      blink_div_q    <= blink_div_d;
      visible_q      <= visible_d;
      popup_active_q <= popup_active_d;
    end
  end

  // --------------------------------------------------------------------------
  // Geometry and address. Everything is widened to 11 bits so that the box
  // edges near the right/bottom of the screen cannot wrap.
  // --------------------------------------------------------------------------
  logic [10:0] x11, y11, top11, rel_x, rel_y;
  logic        in_box;
  logic [18:0] addr_raw;
  logic [18:0] read_address_d;
  logic        flag1_d;

  always_comb begin
    x11      = {1'b0, DrawX};
    y11      = {1'b0, DrawY};
    top11    = C_POS_Y - {{(11-RISE_W){1'b0}}, rise_q};
    in_box   = (x11 >= C_POS_X) && (x11 < C_POS_X + C_SPR_W11) &&
               (y11 >= top11)   && (y11 < top11 + C_SPR_H11);
    rel_x    = x11 - C_POS_X;
    rel_y    = y11 - top11;
    addr_raw = {8'b0, rel_y} * C_SPR_W19 + {8'b0, rel_x};
    read_address_d = in_box ? addr_raw : '0;
    flag1_d  = in_box && (state_q != S_IDLE) && visible_q;
  end

  // --------------------------------------------------------------------------
  // Output pipeline: stage 1 = address + flag, stage 2 = RAM read (flag rides
  // along), stage 3 = palette lookup.
  // --------------------------------------------------------------------------
  logic [18:0] read_address_q;
  logic        flag1_q, flag2_q;
  logic [23:0] ovl_rgb_q, ovl_rgb_d;
  logic        ovl_valid_q, ovl_valid_d;

  always_comb begin
    ovl_valid_d = flag2_q && (spr_data != 3'd0);
    ovl_rgb_d   = 24'h000000;
    if (ovl_valid_d) begin
      case (spr_data)
        3'd1:    ovl_rgb_d = 24'hFFFFFF;
        3'd2:    ovl_rgb_d = 24'hFFD700;
        3'd3:    ovl_rgb_d = 24'hFFA500;
        3'd4:    ovl_rgb_d = 24'hFF4500;
        3'd5:    ovl_rgb_d = 24'h00BFFF;
        3'd6:    ovl_rgb_d = 24'h1E90FF;
        3'd7:    ovl_rgb_d = 24'h202020;
        default: ovl_rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address_q <= '0;
      flag1_q        <= 1'b0;
      flag2_q        <= 1'b0;
      ovl_rgb_q      <= '0;
      ovl_valid_q    <= 1'b0;
    end else begin
      read_address_q <= read_address_d;
      flag1_q        <= flag1_d;
      flag2_q        <= flag1_q;
      ovl_rgb_q      <= ovl_rgb_d;
      ovl_valid_q    <= ovl_valid_d;
    end
  end

  assign read_address = read_address_q;
  assign ovl_rgb      = ovl_rgb_q;
  assign ovl_valid    = ovl_valid_q;
  assign popup_active = popup_active_q;

endmodule

`default_nettype wire

// File: tb/tb_hit_popup_renderer.sv
// ============================================================================
//  Module   : tb_hit_popup_renderer
//  Purpose  : Self-checking bench for hit_popup_renderer. A frame-count based
//             reference model predicts every output each cycle; directed
//             sequences pin key literal values; random traffic follows.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hit_popup_renderer;

  localparam int SPR_W        = 157;
  localparam int SPR_H        = 136;
  localparam int POS_X        = 241;
  localparam int POS_Y        = 180;
  localparam int SHOW_FRAMES  = 60;
  localparam int BLINK_FRAMES = 20;
  localparam int BLINK_PERIOD = 4;
  localparam int RISE_DIV     = 3;
  localparam int RISE_MAX     = 16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        frame_start = 1'b0;
  logic        hit_perfect = 1'b0;
  logic [18:0] read_address;
  logic [2:0]  spr_data = '0;
  logic [23:0] ovl_rgb;
  logic        ovl_valid;
  logic        popup_active;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  bit ram_force2 = 1'b0;

  hit_popup_renderer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .frame_start  (frame_start),
    .hit_perfect  (hit_perfect),
    .read_address (read_address),
    .spr_data     (spr_data),
    .ovl_rgb      (ovl_rgb),
    .ovl_valid    (ovl_valid),
    .popup_active (popup_active)
  );

  always #5 Clk = ~Clk;

  // ---------------- sprite RAM contents (synchronous read) ----------------
  function automatic logic [2:0] mem(input logic [18:0] a, input bit f2);
    logic [18:0] h;
    if (f2) return 3'd2;
    h = a * 19'd13 + (a >> 4);
    return h[2:0];
  endfunction

  always @(posedge Clk) spr_data <= mem(read_address, ram_force2);

  // ---------------- reference model helpers ----------------
  // n = number of frame_starts since the popup was (re)triggered.
  function automatic bit vis_of(input int n);
    if (n < SHOW_FRAMES - BLINK_FRAMES) return 1'b1;
    return (((n - (SHOW_FRAMES - BLINK_FRAMES)) / BLINK_PERIOD) % 2) == 0;
  endfunction

  function automatic int top_of(input int n);
    int r;
    r = n / RISE_DIV;
    if (r > RISE_MAX) r = RISE_MAX;
    return POS_Y - r;
  endfunction

  function automatic bit box_of(input int x, input int y, input int n);
    return (x >= POS_X) && (x < POS_X + SPR_W) &&
           (y >= top_of(n)) && (y < top_of(n) + SPR_H);
  endfunction

  function automatic logic [18:0] addr_of(input int x, input int y, input int n);
    if (!box_of(x, y, n)) return 19'd0;
    return 19'((y - top_of(n)) * SPR_W + (x - POS_X));
  endfunction

  function automatic logic [23:0] pal(input logic [2:0] i);
    case (i)
      3'd1: return 24'hFFFFFF;
      3'd2: return 24'hFFD700;
      3'd3: return 24'hFFA500;
      3'd4: return 24'hFF4500;
      3'd5: return 24'h00BFFF;
      3'd6: return 24'h1E90FF;
      3'd7: return 24'h202020;
      default: return 24'h000000;
    endcase
  endfunction

  // ---------------- reference model ----------------
  bit          m_active;
  int          m_n;
  logic [18:0] m_addr1;
  bit          m_flag1, m_flag2, m_valid;
  logic [2:0]  m_data;
  logic [23:0] m_rgb;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_active <= 1'b0;
      m_n      <= 0;
      m_addr1  <= '0;
      m_flag1  <= 1'b0;
      m_flag2  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_rgb    <= '0;
    end else begin
      m_addr1 <= addr_of(int'(DrawX), int'(DrawY), m_n);
      m_flag1 <= m_active && box_of(int'(DrawX), int'(DrawY), m_n) && vis_of(m_n);
      m_flag2 <= m_flag1;
      m_data  <= mem(m_addr1, ram_force2);
      m_valid <= m_flag2 && (m_data != 3'd0);
      m_rgb   <= (m_flag2 && (m_data != 3'd0)) ? pal(m_data) : 24'h000000;
      if (hit_perfect) begin
        m_active <= 1'b1;
        m_n      <= 0;
      end else if (frame_start && m_active) begin
        m_n <= m_n + 1;
        if (m_n + 1 == SHOW_FRAMES) m_active <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    if (Reset_n && cmp_en) begin
      check("read_address", 32'(read_address), 32'(m_addr1));
      check("ovl_valid",    32'(ovl_valid),    32'(m_valid));
      check("ovl_rgb",      32'(ovl_rgb),      32'(m_rgb));
      check("popup_active", 32'(popup_active), 32'(m_active));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int k);
    for (int i = 0; i < k; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic hit();
    hit_perfect = 1'b1;
    tick();
    hit_perfect = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n = 1'b1;
    cmp_en  = 1'b1;
    tick();
    check("reset_read_address", 32'(read_address), 32'd0);
    check("reset_ovl_valid",    32'(ovl_valid),    32'd0);
    check("reset_ovl_rgb",      32'(ovl_rgb),      32'd0);
    check("reset_popup_active", 32'(popup_active), 32'd0);

    // Coarse full-frame sweep with no popup.
    for (int y = 0; y < 525; y += 5) begin
      for (int x = 0; x < 800; x += 7) begin
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
      end
    end
    check("sweep_ovl_valid", 32'(ovl_valid), 32'd0);

    // Trigger and corner addresses.
    hit();
    ram_force2 = 1'b1;
    DrawX = 10'd241; DrawY = 10'd180; tick();
    check("corner_tl_addr", 32'(read_address), 32'd0);
    DrawX = 10'd397; DrawY = 10'd315; tick();
    check("corner_br_addr", 32'(read_address), 32'd21351);
    DrawX = 10'd0; DrawY = 10'd0; tick();
    check("corner_tl_valid", 32'(ovl_valid), 32'd1);
    check("corner_tl_rgb",   32'(ovl_rgb),   32'hFFD700);
    tick();
    check("corner_br_valid", 32'(ovl_valid), 32'd1);
    check("corner_br_rgb",   32'(ovl_rgb),   32'hFFD700);

    // Rise after 6 frames: top = 178.
    frames(6);
    DrawX = 10'd241; DrawY = 10'd178; tick();
    check("rise_top_addr", 32'(read_address), 32'd0);
    DrawY = 10'd177; tick();
    check("rise_above_addr", 32'(read_address), 32'd0);
    DrawY = 10'd313; tick();
    check("rise_bottom_addr", 32'(read_address), 32'd21195);
    check("rise_top_valid", 32'(ovl_valid), 32'd1);
    tick();
    check("rise_above_valid", 32'(ovl_valid), 32'd0);
    tick();
    check("rise_bottom_valid", 32'(ovl_valid), 32'd1);

    // Into BLINK: after 44 frames the popup is in its first hidden phase.
    frames(38);
    check("blink_active", 32'(popup_active), 32'd1);
    DrawX = 10'd241; DrawY = 10'd166;
    repeat (3) tick();
    check("blink_hidden_valid", 32'(ovl_valid), 32'd0);
    frames(15);
    check("frame59_active", 32'(popup_active), 32'd1);
    frames(1);
    check("frame60_inactive", 32'(popup_active), 32'd0);

    // Retrigger with hit and frame_start together during BLINK.
    hit();
    frames(45);
    hit_perfect = 1'b1; frame_start = 1'b1; tick();
    hit_perfect = 1'b0; frame_start = 1'b0;
    DrawX = 10'd241; DrawY = 10'd180; tick();
    check("retrig_addr", 32'(read_address), 32'd0);
    DrawX = 10'd0; DrawY = 10'd0;
    tick(); tick();
    check("retrig_valid", 32'(ovl_valid), 32'd1);
    frames(59);
    check("retrig_59_active", 32'(popup_active), 32'd1);
    frames(1);
    check("retrig_60_inactive", 32'(popup_active), 32'd0);

    // Asynchronous reset in the middle of SHOW.
    hit();
    DrawX = 10'd300; DrawY = 10'd250;
    repeat (4) tick();
    check("pre_reset_valid", 32'(ovl_valid), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_read_address", 32'(read_address), 32'd0);
    check("async_rst_ovl_valid",    32'(ovl_valid),    32'd0);
    check("async_rst_ovl_rgb",      32'(ovl_rgb),      32'd0);
    check("async_rst_popup_active", 32'(popup_active), 32'd0);
    tick(); tick();
    Reset_n = 1'b1;
    repeat (5) tick();
    check("post_rst_active", 32'(popup_active), 32'd0);
    check("post_rst_valid",  32'(ovl_valid),    32'd0);

    // Random traffic.
    ram_force2 = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      hit_perfect = (i == 0) || ($urandom_range(0, 399) == 0);
      frame_start = ($urandom_range(0, 5) == 0);
      DrawX = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(230, 410))
                                          : 10'($urandom_range(0, 799));
      DrawY = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(150, 330))
                                          : 10'($urandom_range(0, 524));
      tick();
    end
    hit_perfect = 1'b0;
    frame_start = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
